// File: rtl/fft32_frame_ctrl_if.sv
// Handshake and data bus between the FFT frame sequencer, its sample source,
// the twiddle ROM controls, the butterfly input and the stage-0 write-back path.
interface fft32_frame_ctrl_if #(parameter int nb = 9);
  logic            IN_VALID;
  logic            IN_READY;
  logic [nb*4-1:0] IR;
  logic [nb*4-1:0] II;
  logic            START;
  logic            STAGE;
  logic [nb*4-1:0] DR;
  logic [nb*4-1:0] DI;
  logic            D_VALID;
  logic            D_FIRST;
  logic            WB_VALID;
  logic            WB_READY;
  logic [nb*4-1:0] WR;
  logic [nb*4-1:0] WI;
  logic            FRAME_DONE;
  logic            BUSY;

  modport master (
    output IN_VALID, IR, II, WB_VALID, WR, WI,
    input  IN_READY, START, STAGE, DR, DI, D_VALID, D_FIRST, WB_READY, FRAME_DONE, BUSY
  );

  modport slave (
    input  IN_VALID, IR, II, WB_VALID, WR, WI,
    output IN_READY, START, STAGE, DR, DI, D_VALID, D_FIRST, WB_READY, FRAME_DONE, BUSY
  );
endinterface

// File: rtl/fft32_frame_ctrl.sv
// Frame sequencer for the 32-point FFT: buffers one frame, replays it per stage
// in ROM-aligned 4-sample groups, and swaps in the stage-0 results for stage 1.
module fft32_frame_ctrl #(
  parameter int nb     = 9,
  parameter int GROUPS = 8,
  parameter int HOLD   = 4
) (
  input logic               CLK,
  input logic               RST,
  fft32_frame_ctrl_if.slave bus
);

  localparam int PW = $clog2(GROUPS);
  localparam int HW = $clog2(HOLD);
  localparam int CW = $clog2(GROUPS * HOLD);
  localparam int DW = 2 * nb * 4;

  typedef enum logic [2:0] {
    FILL, START0, WAIT0, STREAM0, WB, START1, WAIT1, STREAM1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            stage_q, stage_d;
  logic            armed_q;
  logic            done_q, done_d;
  logic [nb*4-1:0] dr_q, di_q;
  logic [DW-1:0]   mem_q [GROUPS];

  logic            wrEn;
  logic [DW-1:0]   wrData;
  logic            streamD;
  logic            loadEn;

  always_comb begin
    state_d = state_q;
    wrEn    = 1'b0;
    wrData  = {bus.II, bus.IR};
    case (state_q)
      FILL: begin
        wrEn = bus.IN_VALID && armed_q;
        if (wrEn && wptr_q == PW'(GROUPS - 1)) state_d = START0;
      end
      START0:  state_d = WAIT0;
      WAIT0:   if (cnt_q == CW'(1)) state_d = STREAM0;
      STREAM0: if (cnt_q == CW'(GROUPS * HOLD - 1)) state_d = WB;
      WB: begin
        wrEn   = bus.WB_VALID;
        wrData = {bus.WI, bus.WR};
        if (wrEn && wptr_q == PW'(GROUPS - 1)) state_d = START1;
      end
      START1:  state_d = WAIT1;
      WAIT1:   if (cnt_q == CW'(1)) state_d = STREAM1;
      STREAM1: if (cnt_q == CW'(GROUPS * HOLD - 1)) state_d = FILL;
      default: state_d = FILL;
    endcase

    // A single counter paces WAIT and STREAM; it restarts on every state change.
    cnt_d  = (state_d != state_q) ? '0 : cnt_q + CW'(1);
    wptr_d = (state_d != state_q) ? '0 : (wrEn ? wptr_q + PW'(1) : wptr_q);

    stage_d = stage_q;
    if (state_d == START0) stage_d = 1'b0;
    else if (state_d == START1) stage_d = 1'b1;

    done_d  = (state_q == STREAM1) && (state_d == FILL);
    streamD = (state_d == STREAM0) || (state_d == STREAM1);
    loadEn  = streamD && (cnt_d[HW-1:0] == '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FILL;
      wptr_q  <= '0;
      cnt_q   <= '0;
      stage_q <= 1'b0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      dr_q    <= '0;
      di_q    <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      armed_q <= 1'b1;
      done_q  <= done_d;
      // Fetch the next group one cycle early so it appears on the group boundary.
      if (loadEn) begin
        {di_q, dr_q} <= mem_q[cnt_d[CW-1:HW]];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (wrEn) mem_q[wptr_q] <= wrData;
  end

  assign bus.IN_READY   = (state_q == FILL) && armed_q;
  assign bus.WB_READY   = (state_q == WB);
  assign bus.START      = (state_q == START0) || (state_q == START1);
  assign bus.STAGE      = stage_q;
  assign bus.D_VALID    = (state_q == STREAM0) || (state_q == STREAM1);
  assign bus.D_FIRST    = ((state_q == STREAM0) || (state_q == STREAM1)) && (cnt_q[HW-1:0] == '0);
  assign bus.DR         = dr_q;
  assign bus.DI         = di_q;
  assign bus.FRAME_DONE = done_q;
  assign bus.BUSY       = (state_q != FILL);

endmodule
